writeback_queue: RTL
====================

Name: writeback_queue

Overview:
- Producer side of the register-file write port.
- Collects completed results from the ALU and the load path and buffers them in a small in-order FIFO.
- Retires at most one result per cycle by driving RegWre/WriteReg/WriteData into the register file, which commits on the following negedge.
- Exports a per-register pending scoreboard so decode can stall on read-after-write against queued results.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTRW, 2, pointer width; equals log2(DEPTH).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  synchronous reset, active-high.
- AluValid  input  1  ALU result offered this cycle.
- AluReg  input  4  ALU destination register.
- AluData  input  16  ALU result.
- AluReady  output  1  ALU result accepted when AluValid && AluReady.
- MemValid  input  1  load result offered this cycle.
- MemReg  input  4  load destination register.
- MemData  input  16  load result.
- MemReady  output  1  load result accepted when MemValid && MemReady.
- Hold  input  1  freeze retirement; no pop while high.
- RegWre  output  1  register-file write enable (registered).
- WriteReg  output  4  register-file write address (registered).
- WriteData  output  16  register-file write data (registered).
- Pending  output  16  bit r set while any queued or presented entry targets register r.
- Count  output  PTRW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (Rst=1 at posedge):
  - Head and tail pointers and Count return to 0, and all entries are invalidated.
  - RegWre, WriteReg and WriteData return to 0.
  - Pending returns to 0 the following cycle.
  - Reset mid-operation discards every queued result; no write escapes after the reset edge.
- Free space: free = DEPTH - Count, taken from registered Count. A same-cycle pop is not credited, which is deliberately conservative.
- Ready rules (combinational):
  - MemReady = (free >= 1).
  - AluReady = (free >= 2) || (free >= 1 && !MemValid).
  - The load path has priority for the last slot.
- Register 0 filter:
  - A handshake with destination 0 completes (ready honoured, source sees it accepted).
  - Such a result is never enqueued and consumes no slot.
  - Register 15 (T) is enqueued normally; the register file derives the flag value itself.
- Enqueue order when both handshake in the same cycle:
  - MEM entry written at tail, ALU entry at tail+1, tail advances by 2.
  - Rationale: loads belong to older instructions.
  - Pointers wrap modulo DEPTH.
- Pop:
  - Condition: Count != 0 && !Hold.
  - Head entry moves to the output registers: RegWre=1, WriteReg/WriteData = entry fields. Head advances by 1.
  - Otherwise RegWre=0; WriteReg/WriteData hold their previous values.
- Latency: an entry accepted at posedge N, into an empty queue with Hold=0, appears on RegWre at posedge N+1 and is committed at negedge of that cycle.
- Count update: Count_next = Count + pushes - pop. Simultaneous push and pop at Count=DEPTH is impossible because ready is based on registered Count.
- Pending:
  - OR over valid FIFO entries plus the output stage while RegWre=1 (one-hot decode of each register field).
  - Combinational from state; same-cycle inputs are not included.
  - Duplicate targets in the queue keep the bit set until the last matching entry has been presented.
- Hold:
  - Blocks pop only; enqueue continues while space exists.
  - RegWre drops to 0 on the first posedge with Hold=1.
- Full: with Count=DEPTH both readies are 0. Empty: RegWre=0.

Test Plan:
- Reset then AluValid=1, AluReg=3, AluData=16'h1234 for one cycle -> next cycle RegWre=1, WriteReg=3, WriteData=16'h1234; Pending[3]=1 through that cycle, then 0.
- Both valid in the same cycle (Mem r5=16'hAAAA, Alu r6=16'h5555), empty queue -> two consecutive writes: r5 first, then r6; Count peaks at 2.
- Hold=1 with 5 ALU results offered (DEPTH=4) -> first 4 accepted, AluReady=0 for the 5th, Count=4, RegWre=0; release Hold -> 4 writes in FIFO order on back-to-back cycles.
- Count=3 with both sources valid -> MemReady=1, AluReady=0; only the load is enqueued.
- ALU write to r0 and r15 (data 0) -> r0 dropped, RegWre never asserted for it; r15 presented with WriteData=0.
- Rst=1 asserted with 3 entries queued -> next cycle RegWre=0, Count=0, Pending=0; no further writes after release.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: in-order result buffer feeding the register-file write port.
// Accepts ALU and load results, drops writes to r0, retires one entry per
// cycle through registered RegWre/WriteReg/WriteData, and exposes a
// per-register pending mask so decode can stall on queued results.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            AluValid,
  input  logic [3:0]      AluReg,
  input  logic [15:0]     AluData,
  output logic            AluReady,
  input  logic            MemValid,
  input  logic [3:0]      MemReg,
  input  logic [15:0]     MemData,
  output logic            MemReady,
  input  logic            Hold,
  output logic            RegWre,
  output logic [3:0]      WriteReg,
  output logic [15:0]     WriteData,
  output logic [15:0]     Pending,
  output logic [PTRW:0]   Count
);

  localparam logic [PTRW:0] DepthCount = DEPTH;
  localparam logic [PTRW:0] OneSlot    = 1;
  localparam logic [PTRW:0] TwoSlots   = 2;

  logic [3:0]       entryReg   [DEPTH];
  logic [15:0]      entryData  [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic [PTRW-1:0]  headPtr;
  logic [PTRW-1:0]  tailPtr;
  logic [PTRW-1:0]  aluSlot;
  logic [PTRW:0]    freeSlots;
  logic [PTRW:0]    pushCount;
  logic             memPush;
  logic             aluPush;
  logic             doPop;

  // Free space comes from registered Count only, so a same-cycle pop never
  // creates room; the load path gets the last slot because it is older.
  assign freeSlots = DepthCount - Count;
  assign MemReady  = (freeSlots >= OneSlot);
  assign AluReady  = (freeSlots >= TwoSlots) || ((freeSlots >= OneSlot) && !MemValid);

  // Handshakes to r0 complete but never occupy a slot.
  assign memPush   = MemValid && MemReady && (MemReg != 4'd0);
  assign aluPush   = AluValid && AluReady && (AluReg != 4'd0);
  assign aluSlot   = tailPtr + PTRW'(memPush);
  assign pushCount = (PTRW+1)'(memPush) + (PTRW+1)'(aluPush);
  assign doPop     = (Count != '0) && !Hold;

  // Pointer, occupancy, valid-bit and output-stage state; the load entry is
  // placed ahead of the ALU entry when both arrive together.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      Count      <= '0;
      entryValid <= '0;
      RegWre     <= 1'b0;
      WriteReg   <= 4'd0;
      WriteData  <= 16'd0;
    end else begin
      if (doPop) begin
        RegWre              <= 1'b1;
        WriteReg            <= entryReg[headPtr];
        WriteData           <= entryData[headPtr];
        entryValid[headPtr] <= 1'b0;
        headPtr             <= headPtr + 1'b1;
      end else begin
        RegWre <= 1'b0;
      end
      if (memPush) begin
        entryValid[tailPtr] <= 1'b1;
      end
      if (aluPush) begin
        entryValid[aluSlot] <= 1'b1;
      end
      tailPtr <= tailPtr + PTRW'(pushCount);
      Count   <= Count + pushCount - (PTRW+1)'(doPop);
    end
  end

  // Entry payload storage; meaning is carried by entryValid so no reset needed.
  always_ff @(posedge Clk) begin
    if (memPush) begin
      entryReg[tailPtr]  <= MemReg;
      entryData[tailPtr] <= MemData;
    end
    if (aluPush) begin
      entryReg[aluSlot]  <= AluReg;
      entryData[aluSlot] <= AluData;
    end
  end

  // Pending mask: every valid queued destination plus the one being presented.
  always_comb begin
    Pending = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) begin
        Pending[entryReg[i]] = 1'b1;
      end
    end
    if (RegWre) begin
      Pending[WriteReg] = 1'b1;
    end
  end

endmodule
